data_mem_lsu: RTL
=================

Name: data_mem_lsu

Overview:
Load/store initiator that sits between the pipeline's execute stage and the word-wide data RAM. It is the requester side of the data-memory interface, opposite the RAM.
- Accepts one load or store per handshake.
- Drives the RAM's word address, write-enable and write-data, and collects its 1-cycle synchronous read data.
- Implements byte/halfword stores by read-modify-write, because the RAM has no byte enables.
- Returns aligned, sign- or zero-extended load data with a response pulse.

Parameters:
ADDR_W, 14, RAM word-index width (16384 words); mem_addr = req_addr[ADDR_W+1:2], upper address bits ignored (aliasing).

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  unit idle, request accepted when req_valid&req_ready at rising edge
req_write  in  1  1=store, 0=load
req_funct3  in  3  RV32I width code (000 B, 001 H, 010 W, 100 BU, 101 HU)
req_addr  in  32  byte address
req_wdata  in  32  store data (low byte/half used for SB/SH)
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load data (0 for stores/errors)
resp_err  out  1  misaligned or illegal funct3, valid with resp_valid
mem_addr  out  ADDR_W  RAM word index (registered)
mem_we  out  1  RAM write enable
mem_wdata  out  32  RAM write data (registered)
mem_rdata  in  32  RAM read data, valid the cycle after the RAM samples mem_addr

Behaviour:
- FSM states: IDLE, RD, RD_DATA, WR, RESP.
- Moore outputs: req_ready=(state==IDLE), mem_we=(state==WR), resp_valid=(state==RESP).
- Reset (async): state=IDLE; mem_addr, mem_wdata, resp_rdata=0; resp_err=0. mem_we drops immediately, so an aborted RMW never writes.
- IDLE, on accept (edge E0): latch funct3, addr[1:0], wdata, write; mem_addr <= word index.
  - Error: LW/SW with addr[1:0]!=0, LH/LHU/SH with addr[0]=1, or funct3 not legal for the op (store 1xx, load 011/11x) -> RESP with resp_err=1; no RAM access.
  - SW: mem_wdata <= req_wdata -> WR.
  - Load, SB, SH: -> RD.
- RD: RAM samples address at the next edge -> RD_DATA.
- RD_DATA, mem_rdata valid:
  - Load: extract lane by addr[1:0] (little-endian) and sign/zero-extend per funct3 into resp_rdata -> RESP.
  - SB/SH: mem_wdata <= mem_rdata with the selected byte/half replaced by the wdata low bits -> WR.
- WR: RAM writes at the next edge -> RESP.
- RESP: resp_valid=1 for exactly one cycle -> IDLE. resp_rdata/resp_err hold until the next response; cleared to 0 on the next accept.
- Latency from accept edge E0 (resp_valid high after edge En):
  - errors n=1
  - SW n=2
  - loads n=3
  - SB/SH n=4
- Requests arriving while not IDLE are not accepted; the requester holds them.
- No read and write to the RAM in the same cycle, so RAM read-during-write ordering is irrelevant.
- Back-to-back requests: a new accept is possible in the IDLE cycle following RESP.

Decomposition:
- Package lsu_pkg: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the state enum.
- Sub-module lsu_align, combinational: load extract/extend (rdata, addr[1:0], funct3) and store merge (old word, wdata, addr[1:0], funct3).
- FSM and registers stay in data_mem_lsu.

Test Plan:
- RAM[4]=0x8899AABB; LB addr 0x13 -> resp_rdata=0xFFFFFF88 after E3; LBU 0x13 -> 0x00000088; LH 0x12 -> 0xFFFF8899; LW 0x10 -> 0x8899AABB; resp_err=0.
- SW addr 0x20 data 0xDEADBEEF -> mem_we high exactly one cycle with mem_addr=8, mem_wdata=0xDEADBEEF; resp_valid after E2.
- RAM[8]=0x11223344; SB addr 0x21 data 0x000000AB -> one read then one write of 0x1122AB44; SH addr 0x22 data 0xCAFE -> 0xCAFEAB44; no other mem_we pulses.
- LW addr 0x6, SH addr 0x5, store funct3=100 -> resp_err=1, resp_rdata=0, mem_we never asserted, resp_valid after E1.
- Assert reset during RD_DATA of an SB -> req_ready=1 and mem_we=0 immediately; RAM word unchanged; next LW returns the original value.
- req_valid held high with alternating LW/SW for 20 requests -> each accepted only in IDLE, exactly one resp_valid per request, in order, against a scoreboard RAM model.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the data-memory load/store unit: RV32I width codes,
// controller states and the request legality check.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RD_DATA,
    S_WR,
    S_RESP
  } state_t;

  // Unsigned widths exist only for loads; misalignment depends on access width.
  function automatic logic access_err(input logic       write,
                                      input logic [2:0] funct3,
                                      input logic [1:0] addr_lo);
    logic legal;
    logic misaligned;
    legal      = 1'b1;
    misaligned = 1'b0;
    case (funct3)
      F3_B:  ;
      F3_H:  misaligned = addr_lo[0];
      F3_W:  misaligned = (addr_lo != 2'b00);
      F3_BU: legal = !write;
      F3_HU: begin
        legal      = !write;
        misaligned = addr_lo[0];
      end
      default: legal = 1'b0;
    endcase
    return !legal || misaligned;
  endfunction

endpackage

// File: rtl/data_mem_lsu_if.sv
// Word-wide data RAM port: the load/store unit is the master, the RAM the slave.
interface data_mem_lsu_if #(
  parameter int ADDR_W = 14
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport master (output mem_addr, output mem_we, output mem_wdata, input mem_rdata);
  modport slave  (input mem_addr, input mem_we, input mem_wdata, output mem_rdata);
endinterface

// File: rtl/lsu_align.sv
// Little-endian lane handling: load extract/extend and byte/half store merge
// into the word read back from the RAM.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [31:0] lane;

  assign lane = word >> {addr_lo, 3'b000};

  // NOTE: every output of an always_comb gets a default first so no path
  // leaves it unassigned and a latch is never inferred.
  always_comb begin
    load_data = word;
    case (funct3)
      F3_B:    load_data = {{24{lane[7]}}, lane[7:0]};
      F3_BU:   load_data = {24'b0, lane[7:0]};
      F3_H:    load_data = {{16{lane[15]}}, lane[15:0]};
      F3_HU:   load_data = {16'b0, lane[15:0]};
      default: ;
    endcase
  end

  always_comb begin
    merge_data = word;
    case (funct3)
      F3_B:    merge_data[{addr_lo, 3'b000} +: 8]     = wdata[7:0];
      F3_H:    merge_data[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
      default: merge_data = wdata;
    endcase
  end

endmodule

// File: rtl/data_mem_lsu.sv
// Load/store initiator for a word-wide RAM without byte enables; narrow stores
// are done by read-modify-write, loads are returned aligned and extended.
module data_mem_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  data_mem_lsu_if.master        mem
);

  state_t            state, state_next;
  logic              write_q;
  logic [2:0]        funct3_q;
  logic [1:0]        addr_lo_q;
  logic [31:0]       wdata_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic              req_err;
  logic              req_sw;
  logic [31:0]       load_data;
  logic [31:0]       merge_data;
  logic              unused_addr_hi;

  assign req_err        = access_err(req_write, req_funct3, req_addr[1:0]);
  assign req_sw         = req_write && (req_funct3 == F3_W);
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (req_err)     state_next = S_RESP;
          else if (req_sw) state_next = S_WR;
          else             state_next = S_RD;
        end
      end
      S_RD:      state_next = S_RD_DATA;
      S_RD_DATA: state_next = write_q ? S_WR : S_RESP;
      S_WR:      state_next = S_RESP;
      S_RESP:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Moore outputs; mem_we follows the async reset straight to 0.
  always_comb begin
    req_ready  = (state == S_IDLE);
    mem.mem_we = (state == S_WR);
    resp_valid = (state == S_RESP);
  end

  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_q     <= 1'b0;
      funct3_q    <= 3'b000;
      addr_lo_q   <= 2'b00;
      wdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            write_q    <= req_write;
            funct3_q   <= req_funct3;
            addr_lo_q  <= req_addr[1:0];
            wdata_q    <= req_wdata;
            mem_addr_q <= req_addr[ADDR_W+1:2];
            resp_rdata <= '0;
            resp_err   <= req_err;
            if (req_sw && !req_err) mem_wdata_q <= req_wdata;
          end
        end
        S_RD_DATA: begin
          if (write_q) mem_wdata_q <= merge_data;
          else         resp_rdata  <= load_data;
        end
        default: ;
      endcase
    end
  end

  lsu_align u_align (
    .funct3     (funct3_q),
    .addr_lo    (addr_lo_q),
    .word       (mem.mem_rdata),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

endmodule
